axi4_lite_rd_arb: RTL and testbench
===================================

// Module: axi4_lite_rd_arb
// PURPOSE
//  - Round-robin arbiter sharing one AXI4-Lite read master user port among N_REQ requesters.
//  - Grants one requester at a time and holds the grant until that read completes.
//  - Routes the returned read data back to the granted requester.
//  - Sits between client logic (register pollers, status readers) and the AXI4-Lite read master.
// PARAMETERS
//  - N_REQ           4     number of requesters, legal 2..8
//  - ID_W            2     width of grant_id, equals $clog2(N_REQ)
//  - TIMEOUT_CYCLES  1024  watchdog limit in cycles; used only with AXI_RD_ARB_TIMEOUT_EN
// PORTS
//  - clk          in   1         single clock; all logic on posedge
//  - srst         in   1         synchronous reset, active-high
//  - req_addr     in   N_REQ*32  requester i address in bits [32*i+31:32*i]
//  - req_valid    in   N_REQ     per-requester read request
//  - req_ready    out  N_REQ     one-cycle completion pulse to the granted requester
//  - req_rdata    out  32        read data; valid only while a req_ready bit is high
//  - m_rd_addr    out  32        address to the read master
//  - m_rd_valid   out  1         request to the read master
//  - m_rd_ready   in   1         read master completion; m_rd_data is valid in the same cycle
//  - m_rd_data    in   32        read master data
//  - grant_id     out  ID_W      index of the current or last granted requester
//  - busy         out  1         high in any state other than IDLE
//  - timeout_err  out  1         sticky watchdog flag; tied 0 without the macro
// BEHAVIOUR
//  - Reset state: FSM=IDLE, req_ready=0, req_rdata=0, m_rd_valid=0, m_rd_addr=0, grant_id=N_REQ-1,
//    busy=0, timeout_err=0. Requester 0 wins the first arbitration.
//  - FSM is one-hot with three states: IDLE, BUSY, DONE.
//  - IDLE: if any req_valid is high, pick a winner round-robin.
//    - Search order starts at (grant_id+1) mod N_REQ and wraps.
//    - Register grant_id=winner and m_rd_addr=req_addr[winner], set m_rd_valid=1, go to BUSY.
//    - If no req_valid is high, stay in IDLE.
//  - BUSY: hold m_rd_valid=1 and keep m_rd_addr stable.
//    - When m_rd_valid && m_rd_ready, capture m_rd_data into req_rdata, drop m_rd_valid, go to DONE.
//  - DONE: for exactly one cycle, req_ready[grant_id]=1 and all other req_ready bits are 0.
//    - req_rdata holds the captured data. Next state is always IDLE.
//  - Latency: request seen in cycle t -> m_rd_valid high at t+1; m_rd_ready at cycle u -> req_ready at u+1.
//    - The next arbitration happens in IDLE at u+2.
//    - Minimum 3 cycles per transaction; with requesters always pending, grants rotate 0,1,2,3,0...
//  - Requesters must hold req_valid and req_addr until req_ready.
//    - The address is sampled only at grant; later changes to it are ignored.
//    - If a requester drops req_valid while granted, the transaction still completes and the DONE
//      pulse is still issued; the requester ignores it.
//  - Simultaneous requests: only one grant per IDLE cycle; losers wait and are not dropped.
//  - A request arriving during BUSY/DONE is arbitrated at the next IDLE.
//  - m_rd_ready while not in BUSY is ignored.
//  - srst asserted mid-transaction returns all state to reset values on the next edge.
//    - No req_ready pulse is issued for the aborted transaction.
//    - The read master must also be reset by the same srst.
//  - req_rdata is 0 outside DONE, so no stale data is visible.
// CONFIGURATION
//  - AXI_RD_ARB_TIMEOUT_EN defined: add a cycle counter of width $clog2(TIMEOUT_CYCLES+1).
//    - The counter clears on entry to BUSY and increments each BUSY cycle.
//    - When it reaches TIMEOUT_CYCLES, set timeout_err=1 (sticky until srst).
//    - The counter saturates. The transaction is NOT aborted and the FSM keeps waiting.
//  - AXI_RD_ARB_TIMEOUT_EN undefined: no counter is built; timeout_err is constant 0.
// TESTING
//  - Single request: req_valid=4'b0100, addr2=0x0000_0010; m_rd_ready with data 0xDEAD_BEEF 2 cycles later
//    -> m_rd_addr=0x10, grant_id=2, req_ready=4'b0100 for 1 cycle, req_rdata=0xDEADBEEF.
//  - All four requesters held valid, addresses 0x0,0x4,0x8,0xC, m_rd_ready 1 cycle after m_rd_valid
//    -> grant order 0,1,2,3,0 with 4 cycles per grant.
//  - Fairness: requesters 0 and 3 always valid -> grants alternate 0,3,0,3; requester 0 never granted twice in a row.
//  - Requester 1 drops req_valid in BUSY -> m_rd_valid stays high until m_rd_ready; req_ready[1] still pulses once.
//  - srst asserted for 1 cycle in BUSY -> next cycle busy=0, m_rd_valid=0, grant_id=N_REQ-1, no req_ready pulse.
//  - Macro on, TIMEOUT_CYCLES=16, m_rd_ready withheld 20 cycles -> timeout_err rises 16 cycles after BUSY entry.
//    - After a late m_rd_ready the transaction completes normally and timeout_err stays 1.

Source files
------------

// File: rtl/axi4_lite_rd_arb.sv
// Round-robin arbiter sharing one AXI4-Lite read master among N_REQ requesters.
// Optional watchdog enabled by defining AXI_RD_ARB_TIMEOUT_EN (sticky timeout_err).
module axi4_lite_rd_arb #(
   parameter int N_REQ          = 4,
   parameter int ID_W           = $clog2(N_REQ),
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic [N_REQ*32-1:0]   req_addr,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   output logic [31:0]           req_rdata,
   output logic [31:0]           m_rd_addr,
   output logic                  m_rd_valid,
   input  logic                  m_rd_ready,
   input  logic [31:0]           m_rd_data,
   output logic [ID_W-1:0]       grant_id,
   output logic                  busy,
   output logic                  timeout_err
);

   typedef enum logic [2:0] {
      IDLE = 3'b001,
      BUSY = 3'b010,
      DONE = 3'b100
   } state_t;

   state_t          state;
   logic [31:0]     addr_arr [N_REQ];
   logic            any_req;
   logic [ID_W-1:0] winner;
   logic [ID_W-1:0] cand;

   for (genvar i = 0; i < N_REQ; i++) begin : g_addr
      assign addr_arr[i] = req_addr[32*i +: 32];
   end

   // Walk from the farthest candidate back to grant_id+1 so the nearest pending requester wins.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      any_req = 1'b0;
      winner  = '0;
      cand    = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         cand = ID_W'((int'(grant_id) + k) % N_REQ);
         if (req_valid[cand]) begin
            any_req = 1'b1;
            winner  = cand;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (srst) begin
         state      <= IDLE;
         req_ready  <= '0;
         req_rdata  <= '0;
         m_rd_valid <= 1'b0;
         m_rd_addr  <= '0;
         grant_id   <= ID_W'(N_REQ - 1);
      end else begin
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  grant_id   <= winner;
                  m_rd_addr  <= addr_arr[winner];
                  m_rd_valid <= 1'b1;
                  state      <= BUSY;
               end
            end
            BUSY: begin
               if (m_rd_valid && m_rd_ready) begin
                  req_rdata  <= m_rd_data;
                  req_ready  <= N_REQ'(1) << grant_id;
                  m_rd_valid <= 1'b0;
                  state      <= DONE;
               end
            end
            DONE: begin
               // Clearing rdata here keeps stale read data invisible outside the pulse.
               req_ready <= '0;
               req_rdata <= '0;
               state     <= IDLE;
            end
            default: begin
               req_ready  <= '0;
               req_rdata  <= '0;
               m_rd_valid <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state != IDLE);

`ifdef AXI_RD_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] to_cnt;
   logic             to_flag;

   // The flag rises on the edge where the count reaches the limit; the read keeps waiting.
   always_ff @(posedge clk) begin
      if (srst) begin
         to_cnt  <= '0;
         to_flag <= 1'b0;
      end else if (state == IDLE && any_req) begin
         to_cnt <= '0;
      end else if (state == BUSY) begin
         if (to_cnt != CNT_W'(TIMEOUT_CYCLES))
            to_cnt <= to_cnt + 1'b1;
         if (to_cnt >= CNT_W'(TIMEOUT_CYCLES - 1))
            to_flag <= 1'b1;
      end
   end

   assign timeout_err = to_flag;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_lite_rd_arb.sv
// Self-checking bench for axi4_lite_rd_arb: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_axi4_lite_rd_arb;

   localparam int N_REQ          = 4;
   localparam int ID_W           = 2;
   localparam int TIMEOUT_CYCLES = 16;

   logic                clk = 1'b0;
   logic                srst;
   logic [N_REQ*32-1:0] req_addr;
   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ-1:0]    req_ready;
   logic [31:0]         req_rdata;
   logic [31:0]         m_rd_addr;
   logic                m_rd_valid;
   logic                m_rd_ready;
   logic [31:0]         m_rd_data;
   logic [ID_W-1:0]     grant_id;
   logic                busy;
   logic                timeout_err;

   int          n_checks = 0;
   int          n_errors = 0;
   int          last_id;
   logic [31:0] last_addr;
   logic        exp_to;

   always #5 clk = ~clk;

   axi4_lite_rd_arb #(
      .N_REQ          (N_REQ),
      .ID_W           (ID_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk         (clk),
      .srst        (srst),
      .req_addr    (req_addr),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_rdata   (req_rdata),
      .m_rd_addr   (m_rd_addr),
      .m_rd_valid  (m_rd_valid),
      .m_rd_ready  (m_rd_ready),
      .m_rd_data   (m_rd_data),
      .grant_id    (grant_id),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One clock: inputs are sampled at posedge, outputs are read back at the following negedge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect_outs(input string tag, input logic e_busy, input logic e_mv,
                              input logic [31:0] e_addr, input int e_gid,
                              input logic [N_REQ-1:0] e_rdy, input logic [31:0] e_data);
      check({tag, ".busy"},        32'(busy),        32'(e_busy));
      check({tag, ".m_rd_valid"},  32'(m_rd_valid),  32'(e_mv));
      check({tag, ".m_rd_addr"},   m_rd_addr,        e_addr);
      check({tag, ".grant_id"},    32'(grant_id),    32'(e_gid));
      check({tag, ".req_ready"},   32'(req_ready),   32'(e_rdy));
      check({tag, ".req_rdata"},   req_rdata,        e_data);
      check({tag, ".timeout_err"}, 32'(timeout_err), 32'(exp_to));
   endtask

   function automatic int rr_pick(input logic [N_REQ-1:0] v, input int last);
      for (int k = 1; k <= N_REQ; k++) begin
         if (v[(last + k) % N_REQ]) return (last + k) % N_REQ;
      end
      return -1;
   endfunction

   function automatic logic [31:0] addr_of(input int i);
      return req_addr[32*i +: 32];
   endfunction

   task automatic set_addr(input int i, input logic [31:0] a);
      req_addr[32*i +: 32] = a;
   endtask

   task automatic model_reset();
      last_id   = N_REQ - 1;
      last_addr = '0;
      exp_to    = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      srst       = 1'b1;
      m_rd_ready = 1'b1;
      step();
      model_reset();
      expect_outs(tag, 1'b0, 1'b0, 32'h0, N_REQ - 1, '0, 32'h0);
      srst       = 1'b0;
      m_rd_ready = 1'b0;
   endtask

   task automatic bump_timeout(input int busy_cycles);
`ifdef AXI_RD_ARB_TIMEOUT_EN
      if (busy_cycles >= TIMEOUT_CYCLES) exp_to = 1'b1;
`else
      if (busy_cycles < 0) exp_to = 1'b1;
`endif
   endtask

   // One full read: arbitration edge, wait_cycles stalled BUSY edges, completion edge, DONE edge.
   task automatic run_txn(input string tag, input logic [N_REQ-1:0] vld, input int exp_w,
                          input int wait_cycles, input logic [31:0] data,
                          input bit drop_in_busy, input bit scramble, output int w);
      logic [31:0] gaddr;
      int          busy_cycles;
      req_valid  = vld;
      m_rd_ready = 1'($urandom_range(0, 1));
      m_rd_data  = $urandom;
      w          = (exp_w >= 0) ? exp_w : rr_pick(vld, last_id);
      gaddr      = addr_of(w);
      step();
      last_id     = w;
      last_addr   = gaddr;
      busy_cycles = 0;
      expect_outs({tag, "_grant"}, 1'b1, 1'b1, gaddr, w, '0, 32'h0);
      for (int k = 0; k < wait_cycles; k++) begin
         m_rd_ready = 1'b0;
         if (drop_in_busy) req_valid[w] = 1'b0;
         if (scramble) set_addr(w, $urandom);
         step();
         busy_cycles++;
         bump_timeout(busy_cycles);
         expect_outs({tag, "_wait"}, 1'b1, 1'b1, gaddr, w, '0, 32'h0);
      end
      m_rd_ready = 1'b1;
      m_rd_data  = data;
      step();
      busy_cycles++;
      bump_timeout(busy_cycles);
      expect_outs({tag, "_done"}, 1'b1, 1'b0, gaddr, w, N_REQ'(1) << w, data);
      m_rd_ready = 1'($urandom_range(0, 1));
      m_rd_data  = $urandom;
      step();
      expect_outs({tag, "_idle"}, 1'b0, 1'b0, gaddr, w, '0, 32'h0);
   endtask

   initial begin
      int                w;
      logic [N_REQ-1:0]  pend;
      logic [N_REQ-1:0]  fresh;
      int                order_rot  [5] = '{0, 1, 2, 3, 0};
      int                order_fair [4] = '{0, 3, 0, 3};

      srst       = 1'b1;
      req_addr   = '0;
      req_valid  = '0;
      m_rd_ready = 1'b0;
      m_rd_data  = '0;
      model_reset();
      step();
      step();
      expect_outs("reset", 1'b0, 1'b0, 32'h0, N_REQ - 1, '0, 32'h0);
      srst = 1'b0;

      // Stray m_rd_ready with no grant outstanding must be ignored.
      m_rd_ready = 1'b1;
      step();
      expect_outs("idle_noreq", 1'b0, 1'b0, 32'h0, N_REQ - 1, '0, 32'h0);
      m_rd_ready = 1'b0;

      set_addr(2, 32'h0000_0010);
      run_txn("single", 4'b0100, 2, 1, 32'hDEAD_BEEF, 1'b0, 1'b0, w);
      req_valid = '0;

      do_reset("reset2");
      for (int i = 0; i < N_REQ; i++) set_addr(i, 32'(4 * i));
      foreach (order_rot[i]) run_txn("rotate", 4'b1111, order_rot[i], 1, $urandom, 1'b0, 1'b0, w);

      do_reset("reset3");
      foreach (order_fair[i]) run_txn("fair", 4'b1001, order_fair[i], 1, $urandom, 1'b0, 1'b0, w);

      set_addr(1, 32'h0000_0104);
      run_txn("drop", 4'b0010, 1, 2, 32'hCAFE_F00D, 1'b1, 1'b0, w);
      req_valid = '0;

      // Abort an in-flight read with srst: no pulse, all state back to reset values.
      set_addr(2, 32'h0000_0020);
      req_valid = 4'b0100;
      step();
      expect_outs("abort_grant", 1'b1, 1'b1, 32'h20, 2, '0, 32'h0);
      srst       = 1'b1;
      m_rd_ready = 1'b1;
      m_rd_data  = 32'h1234_5678;
      step();
      model_reset();
      expect_outs("abort_rst", 1'b0, 1'b0, 32'h0, N_REQ - 1, '0, 32'h0);
      srst       = 1'b0;
      m_rd_ready = 1'b0;
      req_valid  = '0;
      step();
      expect_outs("abort_after", 1'b0, 1'b0, 32'h0, N_REQ - 1, '0, 32'h0);
      run_txn("post_abort", 4'b0110, 1, 0, 32'h0BAD_F00D, 1'b0, 1'b0, w);

      // Randomized traffic: pending requests accumulate, losers stay pending until served.
      pend = '0;
      for (int t = 0; t < 40; t++) begin
         fresh = N_REQ'($urandom);
         for (int i = 0; i < N_REQ; i++)
            if (fresh[i] && !pend[i]) set_addr(i, $urandom & 32'hFFFF_FFFC);
         pend = pend | fresh;
         if (pend == '0) begin
            req_valid = '0;
            step();
            expect_outs("rand_gap", 1'b0, 1'b0, last_addr, last_id, '0, 32'h0);
            continue;
         end
         run_txn("rand", pend, -1, $urandom_range(0, 3), $urandom, 1'b0, 1'($urandom_range(0, 1)), w);
         pend[w] = 1'b0;
      end

      // Long stall: watchdog fires after TIMEOUT_CYCLES BUSY cycles when built in, read still completes.
      run_txn("stall", pend | 4'b0001, -1, 20, 32'h5A5A_A5A5, 1'b0, 1'b0, w);
      req_valid = '0;
      step();
      expect_outs("final_idle", 1'b0, 1'b0, last_addr, last_id, '0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
